// File: rtl/sensor_poll_scheduler.sv
// Round-robin poller over temperature/humidity slots of all sensor addresses.
// Yields to the host controller and spaces polls by a programmable interval.
module sensor_poll_scheduler #(
    parameter int NUM_ADDR      = 32,
    parameter int POLL_INTERVAL = 50_000_000,
    parameter int TIMEOUT       = 150_000_000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cmd_valid,
    input  logic [7:0]          cmd_code,
    input  logic [7:0]          cmd_address,
    input  logic                host_busy,
    input  logic                sensor_done,
    output logic                cmd_accept,
    output logic                cmd_reject,
    output logic                sensor_req,
    output logic [7:0]          sensor_command,
    output logic [7:0]          sensor_address,
    output logic                timeout_err,
    output logic [NUM_ADDR-1:0] temp_mask,
    output logic [NUM_ADDR-1:0] hum_mask
);

    localparam int NS = 2 * NUM_ADDR;
    localparam int PW = $clog2(NS);
    localparam int AW = $clog2(NUM_ADDR);
    localparam int WW = $clog2(POLL_INTERVAL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_REQ
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [NUM_ADDR-1:0]   r_temp;
    logic [NUM_ADDR-1:0]   r_hum;
    logic                  r_acc;
    logic                  r_rej;
    logic [PW-1:0]         r_ptr;
    logic [WW-1:0]         r_wait;
    logic [TW-1:0]         r_tmo;
    logic                  r_tmo_err;
    logic [7:0]            r_cmd;
    logic [7:0]            r_addr;
    logic [NS-1:0]         w_slots;
    logic                  w_found;
    logic [PW-1:0]         w_pick;
    logic [PW:0]           w_idx;
    logic                  w_addr_ok;
    logic                  w_code_ok;
    logic [AW-1:0]         w_a;
    logic                  w_tmo_hit;

    assign w_addr_ok = ({24'd0, cmd_address} < 32'(NUM_ADDR));
    assign w_code_ok = (cmd_code >= 8'd4) && (cmd_code <= 8'd7);
    assign w_a       = cmd_address[AW-1:0];
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    // Apply host set/clear commands to the masks and pulse accept/reject.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_temp <= '0;
            r_hum  <= '0;
            r_acc  <= 1'b0;
            r_rej  <= 1'b0;
        end else begin
            r_acc <= 1'b0;
            r_rej <= 1'b0;
            if (cmd_valid) begin
                if (w_addr_ok && w_code_ok) begin
                    r_acc <= 1'b1;
                    case (cmd_code[1:0])
                        2'd0:    r_temp[w_a] <= 1'b1;
                        2'd1:    r_hum[w_a]  <= 1'b1;
                        2'd2:    r_temp[w_a] <= 1'b0;
                        default: r_hum[w_a]  <= 1'b0;
                    endcase
                end else begin
                    r_rej <= 1'b1;
                end
            end
        end
    end

    // Interleave the masks into slot order: slot 2*a+kind.
    always_comb begin
        w_slots = '0;
        for (int a = 0; a < NUM_ADDR; a++) begin
            w_slots[2*a]   = r_temp[a];
            w_slots[2*a+1] = r_hum[a];
        end
    end

    // Rotating priority: nearest active slot after ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = NS; i >= 1; i--) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_idx >= (PW+1)'(NS))
                w_idx = w_idx - (PW+1)'(NS);
            if (w_slots[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if ((|r_temp || |r_hum) && !host_busy && r_wait == '0)
                    w_next = S_SCAN;
            end
            S_SCAN: begin
                w_next = w_found ? S_REQ : S_IDLE;
            end
            S_REQ: begin
                if (sensor_done || w_tmo_hit)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Poll datapath: pointer, latched target, interval and timeout counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= PW'(NS - 1);
            r_wait    <= '0;
            r_tmo     <= '0;
            r_tmo_err <= 1'b0;
            r_cmd     <= '0;
            r_addr    <= '0;
        end else begin
            r_tmo_err <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (r_wait != '0)
                        r_wait <= r_wait - 1'b1;
                end
                S_SCAN: begin
                    r_tmo <= '0;
                    if (w_found) begin
                        r_ptr  <= w_pick;
                        r_cmd  <= w_pick[0] ? 8'd5 : 8'd4;
                        r_addr <= 8'(w_pick[PW-1:1]);
                    end
                end
                S_REQ: begin
                    if (sensor_done) begin
                        r_wait <= WW'(POLL_INTERVAL);
                        r_tmo  <= '0;
                    end else if (w_tmo_hit) begin
                        r_wait    <= WW'(POLL_INTERVAL);
                        r_tmo     <= '0;
                        r_tmo_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_accept     = r_acc;
    assign cmd_reject     = r_rej;
    assign sensor_req     = (r_state == S_REQ);
    assign sensor_command = r_cmd;
    assign sensor_address = r_addr;
    assign timeout_err    = r_tmo_err;
    assign temp_mask      = r_temp;
    assign hum_mask       = r_hum;

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler with shortened interval/timeout.
// Inputs change 1 ns after the rising edge; outputs are read there too.
module tb_sensor_poll_scheduler;

    localparam int NA = 32;
    localparam int PI = 100;
    localparam int TO = 500;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic [7:0]    cmd_code;
    logic [7:0]    cmd_address;
    logic          host_busy;
    logic          sensor_done;
    logic          cmd_accept;
    logic          cmd_reject;
    logic          sensor_req;
    logic [7:0]    sensor_command;
    logic [7:0]    sensor_address;
    logic          timeout_err;
    logic [NA-1:0] temp_mask;
    logic [NA-1:0] hum_mask;

    int n_cmp = 0;
    int n_bad = 0;

    sensor_poll_scheduler #(
        .NUM_ADDR      (NA),
        .POLL_INTERVAL (PI),
        .TIMEOUT       (TO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .cmd_address    (cmd_address),
        .host_busy      (host_busy),
        .sensor_done    (sensor_done),
        .cmd_accept     (cmd_accept),
        .cmd_reject     (cmd_reject),
        .sensor_req     (sensor_req),
        .sensor_command (sensor_command),
        .sensor_address (sensor_address),
        .timeout_err    (timeout_err),
        .temp_mask      (temp_mask),
        .hum_mask       (hum_mask)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] a);
        cmd_valid   = 1'b1;
        cmd_code    = c;
        cmd_address = a;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_req(input int lim, output int n);
        n = 0;
        while (!sensor_req && n < lim) begin
            tick();
            n++;
        end
        chk("req_seen", {63'd0, sensor_req}, 64'd1);
    endtask

    task automatic expect_req(input string tag,
                              input int c, input int a);
        int n;
        wait_req(200, n);
        chk({tag, "_cmd"}, 64'(sensor_command), 64'(c));
        chk({tag, "_addr"}, 64'(sensor_address), 64'(a));
    endtask

    task automatic give_done(input string tag);
        sensor_done = 1'b1;
        tick();
        sensor_done = 1'b0;
        chk({tag, "_drop"}, {63'd0, sensor_req}, 64'd0);
    endtask

    task automatic idle_watch(input string tag, input int cyc);
        int seen;
        seen = 0;
        for (int i = 0; i < cyc; i++) begin
            tick();
            if (sensor_req) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_code    = '0;
        cmd_address = '0;
        host_busy   = 1'b0;
        sensor_done = 1'b0;
        tick();
        tick();
        chk("rst_req", {63'd0, sensor_req}, 64'd0);
        chk("rst_acc", {62'd0, cmd_accept, cmd_reject}, 64'd0);
        chk("rst_cmd", {48'd0, sensor_command, sensor_address}, 64'd0);
        chk("rst_tmo", {63'd0, timeout_err}, 64'd0);
        chk("rst_mask", {temp_mask, hum_mask}, 64'd0);
        reset_n = 1'b1;
        tick();

        // Single temperature slot, request latency, interval.
        send_cmd(8'd4, 8'd3);
        chk("t1_acc", {63'd0, cmd_accept}, 64'd1);
        chk("t1_rej", {63'd0, cmd_reject}, 64'd0);
        chk("t1_tmask", 64'(temp_mask), 64'h8);
        tick();
        chk("t1_req_t2", {63'd0, sensor_req}, 64'd0);
        tick();
        chk("t1_req_t3", {63'd0, sensor_req}, 64'd1);
        chk("t1_cmd", 64'(sensor_command), 64'd4);
        chk("t1_addr", 64'(sensor_address), 64'd3);
        give_done("t1");
        wait_req(200, n);
        chk("t1_gap", 64'(n), 64'(PI + 2));
        chk("t1_cmd2", 64'(sensor_command), 64'd4);
        chk("t1_addr2", 64'(sensor_address), 64'd3);

        // Fresh start so the round-robin begins at slot 0.
        reset_n = 1'b0;
        #1;
        chk("rr_rst_req", {63'd0, sensor_req}, 64'd0);
        tick();
        reset_n = 1'b1;
        send_cmd(8'd4, 8'd1);
        send_cmd(8'd5, 8'd1);
        send_cmd(8'd4, 8'd7);
        expect_req("rr0", 4, 1);
        give_done("rr0");
        expect_req("rr1", 5, 1);
        give_done("rr1");
        expect_req("rr2", 4, 7);
        give_done("rr2");
        expect_req("rr3", 4, 1);
        give_done("rr3");
        expect_req("rr4", 5, 1);
        send_cmd(8'd7, 8'd1);
        chk("clr_acc", {63'd0, cmd_accept}, 64'd1);
        chk("clr_hmask", 64'(hum_mask), 64'd0);
        chk("clr_keep", {63'd0, sensor_req}, 64'd1);
        give_done("rr4");
        expect_req("rr5", 4, 7);
        give_done("rr5");
        expect_req("rr6", 4, 1);
        send_cmd(8'd6, 8'd1);
        chk("clr1_tmask", 64'(temp_mask), 64'h80);
        // Command and done in the same cycle.
        cmd_valid   = 1'b1;
        cmd_code    = 8'd6;
        cmd_address = 8'd7;
        sensor_done = 1'b1;
        tick();
        cmd_valid   = 1'b0;
        sensor_done = 1'b0;
        chk("both_acc", {63'd0, cmd_accept}, 64'd1);
        chk("both_drop", {63'd0, sensor_req}, 64'd0);
        chk("both_tmask", 64'(temp_mask), 64'd0);
        idle_watch("empty_noreq", 300);

        // Rejections.
        send_cmd(8'd4, 8'd32);
        chk("rej_addr", {62'd0, cmd_accept, cmd_reject}, 64'd1);
        send_cmd(8'd2, 8'd0);
        chk("rej_code", {62'd0, cmd_accept, cmd_reject}, 64'd1);
        chk("rej_mask", {temp_mask, hum_mask}, 64'd0);
        idle_watch("rej_noreq", 20);

        // Host ownership blocks new polls but not a running one.
        host_busy = 1'b1;
        send_cmd(8'd4, 8'd2);
        send_cmd(8'd5, 8'd2);
        chk("hb_mask", {temp_mask, hum_mask}, {32'h4, 32'h4});
        idle_watch("hb_noreq", 50);
        host_busy = 1'b0;
        tick();
        chk("hb_rel1", {63'd0, sensor_req}, 64'd0);
        tick();
        chk("hb_rel2", {63'd0, sensor_req}, 64'd1);
        chk("hb_cmd", 64'(sensor_command), 64'd4);
        chk("hb_addr", 64'(sensor_address), 64'd2);

        // Timeout, with host_busy raised during the request.
        host_busy = 1'b1;
        n = 0;
        while (sensor_req && n < TO + 50) begin
            tick();
            n++;
            if (n == 3) host_busy = 1'b0;
            if (n == TO - 1)
                chk("to_early", {63'd0, timeout_err}, 64'd0);
        end
        chk("to_len", 64'(n), 64'(TO));
        chk("to_err", {63'd0, timeout_err}, 64'd1);
        tick();
        chk("to_err_end", {63'd0, timeout_err}, 64'd0);
        wait_req(200, n);
        chk("to_gap", 64'(n), 64'(PI + 1));
        chk("to_cmd", 64'(sensor_command), 64'd5);
        chk("to_addr", 64'(sensor_address), 64'd2);

        // Asynchronous reset in the middle of a request.
        tick();
        reset_n = 1'b0;
        #1;
        chk("ar_req", {63'd0, sensor_req}, 64'd0);
        chk("ar_mask", {temp_mask, hum_mask}, 64'd0);
        chk("ar_cmd", {48'd0, sensor_command, sensor_address}, 64'd0);
        sensor_done = 1'b1;
        tick();
        sensor_done = 1'b0;
        reset_n = 1'b1;
        tick();
        sensor_done = 1'b1;
        tick();
        sensor_done = 1'b0;
        idle_watch("ar_noreq", 20);
        chk("ar_tmo", {63'd0, timeout_err}, 64'd0);
        chk("ar_mask2", {temp_mask, hum_mask}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
